// File: rtl/demux_rr_sched.sv
// demux_rr_sched: round-robin time-slot scheduler driving a registered 1:16
// demultiplexer. Accepted serial beats are routed one-hot onto y with one
// cycle of latency. The block dwells (dwell+1) beats on each enabled channel,
// then moves to the next enabled channel in circular order.
module demux_rr_sched #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [15:0]        en_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               din,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [3:0]         sel,
  output logic [15:0]        y,
  output logic               dout_valid,
  output logic               wrap,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [3:0]         sel_reg, sel_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;
  logic               stop_reg, stop_next;
  logic [15:0]        y_reg, y_next;
  logic               dv_reg, dv_next;
  logic               wrap_reg, wrap_next;

  logic               accept;
  logic [3:0]         first_idx;
  logic [15:0]        rot_mask;
  logic [3:0]         step;
  logic [3:0]         adv_sel;
  logic [15:0]        y_route;

  assign accept = in_valid && (state_reg == RUN);

  // Rotate the mask so bit 0 is the channel after sel and bit 15 is sel itself;
  // the lowest set bit of the rotated view is then the next channel in order.
  // y_route places din on the currently selected output only.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_chan
      assign rot_mask[gi] = en_mask[sel_reg + 4'(gi + 1)];
      assign y_route[gi]  = din && (sel_reg == 4'(gi));
    end
  endgenerate

  // Lowest enabled channel, used when leaving IDLE.
  always_comb begin
    first_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (en_mask[i]) first_idx = 4'(i);
    end
  end

  // Distance (minus one) from sel to the next enabled channel, wrapping mod 16.
  always_comb begin
    step = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rot_mask[i]) step = 4'(i);
    end
  end

  assign adv_sel = sel_reg + step + 4'd1;

  // Next-state and datapath decode; all register inputs defaulted first.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    dwell_next = dwell_reg;
    stop_next  = stop_reg;
    y_next     = '0;
    dv_next    = 1'b0;
    wrap_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (stop) stop_next = 1'b1;
        if (start && (en_mask != 16'd0)) begin
          state_next = RUN;
          sel_next   = first_idx;
          cnt_next   = '0;
          dwell_next = dwell;
          stop_next  = 1'b0;
        end
      end
      RUN: begin
        stop_next = stop_reg || stop;
        if (accept) begin
          y_next  = y_route;
          dv_next = 1'b1;
          if (cnt_reg == dwell_reg) begin
            // Slot boundary: stop wins, then an empty mask, else advance.
            cnt_next  = '0;
            stop_next = 1'b0;
            if (stop_reg || stop) begin
              state_next = IDLE;
            end else if (en_mask == 16'd0) begin
              state_next = IDLE;
            end else begin
              sel_next   = adv_sel;
              dwell_next = dwell;
              wrap_next  = (adv_sel <= sel_reg);
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= 4'd0;
      cnt_reg   <= '0;
      dwell_reg <= '0;
      stop_reg  <= 1'b0;
      y_reg     <= 16'd0;
      dv_reg    <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
      dwell_reg <= dwell_next;
      stop_reg  <= stop_next;
      y_reg     <= y_next;
      dv_reg    <= dv_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign in_ready   = (state_reg == RUN);
  assign busy       = (state_reg == RUN);
  assign sel        = sel_reg;
  assign y          = y_reg;
  assign dout_valid = dv_reg;
  assign wrap       = wrap_reg;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Testbench for demux_rr_sched: directed scenarios plus randomized traffic,
// all checked against a slot-level behavioural model of the scheduler.
module tb_demux_rr_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] en_mask = 16'd0;
  logic [3:0]  dwell = 4'd0;
  logic        din = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  sel;
  logic [15:0] y;
  logic        dout_valid;
  logic        wrap;
  logic        busy;

  int total = 0;
  int bad = 0;

  demux_rr_sched #(.DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en_mask(en_mask),
    .dwell(dwell), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .y(y), .dout_valid(dout_valid), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: running flag, current channel, beats left in the slot, stop request.
  bit          m_run;
  logic [3:0]  m_sel;
  int          m_left;
  bit          m_stop;
  logic [15:0] m_y;
  bit          m_dv;
  bit          m_wrap;

  wire [23:0] act = {busy, in_ready, wrap, dout_valid, sel, y};

  function automatic logic [23:0] exp_vec();
    return {m_run, m_run, m_wrap, m_dv, m_sel, m_y};
  endfunction

  task automatic model_reset();
    m_run = 0; m_sel = 4'd0; m_left = 0; m_stop = 0;
    m_y = 16'd0; m_dv = 0; m_wrap = 0;
  endtask

  // Apply one clock edge of scheduler rules to the model.
  task automatic model_edge(input bit st, input bit sp, input logic [15:0] mask,
                            input logic [3:0] dw, input bit d, input bit v);
    logic [3:0] old;
    bit found;
    m_y = 16'd0; m_dv = 0; m_wrap = 0;
    if (sp) m_stop = 1;
    if (!m_run) begin
      if (st && mask != 16'd0) begin
        m_run = 1;
        m_stop = 0;
        m_left = int'(dw) + 1;
        found = 0;
        for (int k = 0; k < 16; k++)
          if (!found && mask[k]) begin m_sel = 4'(k); found = 1; end
      end
    end else if (v) begin
      m_dv = 1;
      m_y[m_sel] = d;
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_stop || mask == 16'd0) begin
          m_run = 0;
        end else begin
          old = m_sel;
          found = 0;
          for (int k = 1; k <= 16; k++)
            if (!found && mask[(int'(old) + k) % 16]) begin
              m_sel = 4'((int'(old) + k) % 16); found = 1;
            end
          m_wrap = (m_sel <= old);
          m_left = int'(dw) + 1;
        end
        m_stop = 0;
      end
    end
  endtask

  task automatic cycle(input bit st, input bit sp, input logic [15:0] mask,
                       input logic [3:0] dw, input bit d, input bit v);
    @(negedge clk);
    start = st; stop = sp; en_mask = mask; dwell = dw; din = d; in_valid = v;
    @(posedge clk);
    model_edge(st, sp, mask, dw, d, v);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; stop = 0; in_valid = 0; din = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (act !== 24'd0) begin bad++; $display("FAIL reset_init: got %h want %h", act, 24'd0); end
    do_reset();
    cycle(1, 0, 16'h0001, 4'd3, 1, 0);
    cycle(0, 0, 16'h0001, 4'd3, 1, 1);
    total++;
    if (act !== exp_vec()) begin bad++; $display("FAIL reset_prerun: got %h want %h", act, exp_vec()); end
    @(negedge clk);
    in_valid = 1; din = 1;
    #2 rst = 1;
    #1;
    total++;
    if (act !== 24'd0) begin bad++; $display("FAIL reset_async: got %h want %h", act, 24'd0); end
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 16'h0001, 4'd0, 1, 1);
      total++;
      if (act !== exp_vec() || in_ready !== 1'b0) begin
        bad++; $display("FAIL reset_idle%0d: got %h want %h", i, act, exp_vec());
      end
    end
  endtask

  task automatic test_rotation();
    logic [15:0] ytab [6] = '{16'h0001, 16'h0000, 16'h0004, 16'h0004, 16'h0000, 16'h0001};
    bit          dtab [6] = '{1, 0, 1, 1, 0, 1};
    do_reset();
    cycle(1, 0, 16'h0005, 4'd1, 0, 0);
    total++;
    if (act !== exp_vec() || sel !== 4'd0) begin bad++; $display("FAIL rot_start: got %h want %h", act, exp_vec()); end
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 16'h0005, 4'd1, dtab[i], 1);
      total++;
      if (act !== exp_vec()) begin bad++; $display("FAIL rot_vec%0d: got %h want %h", i, act, exp_vec()); end
      total++;
      if (y !== ytab[i] || wrap !== (i == 3)) begin
        bad++; $display("FAIL rot_y%0d: got y=%h wrap=%b want y=%h wrap=%b", i, y, wrap, ytab[i], i == 3);
      end
    end
  endtask

  task automatic test_skip_wrap();
    logic [15:0] ytab [4] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};
    bit          wtab [4] = '{0, 1, 0, 1};
    do_reset();
    cycle(1, 0, 16'h8001, 4'd0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 16'h8001, 4'd0, 1, 1);
      total++;
      if (act !== exp_vec()) begin bad++; $display("FAIL skip_vec%0d: got %h want %h", i, act, exp_vec()); end
      total++;
      if (y !== ytab[i] || wrap !== wtab[i]) begin
        bad++; $display("FAIL skip_y%0d: got y=%h wrap=%b want y=%h wrap=%b", i, y, wrap, ytab[i], wtab[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit vtab [4] = '{1, 0, 0, 1};
    do_reset();
    cycle(1, 0, 16'h0003, 4'd1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 16'h0003, 4'd1, 1, vtab[i]);
      total++;
      if (act !== exp_vec() || dout_valid !== vtab[i]) begin
        bad++; $display("FAIL bp_vec%0d: got %h want %h", i, act, exp_vec());
      end
    end
    total++;
    if (sel !== 4'd1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_adv: got sel=%0d rdy=%b want sel=1 rdy=1", sel, in_ready);
    end
  endtask

  task automatic test_stop_maskzero();
    do_reset();
    cycle(1, 0, 16'h0001, 4'd3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, i == 0, 16'h0001, 4'd3, 1, 1);
      total++;
      if (act !== exp_vec() || dout_valid !== 1'b1 || busy !== (i != 3)) begin
        bad++; $display("FAIL stop_beat%0d: got %h want %h", i, act, exp_vec());
      end
    end
    do_reset();
    cycle(1, 0, 16'h0002, 4'd1, 0, 0);
    cycle(0, 0, 16'h0000, 4'd1, 1, 1);
    total++;
    if (act !== exp_vec() || busy !== 1'b1) begin bad++; $display("FAIL mz_mid: got %h want %h", act, exp_vec()); end
    cycle(0, 0, 16'h0000, 4'd1, 1, 1);
    total++;
    if (act !== exp_vec() || busy !== 1'b0 || y !== 16'h0002) begin
      bad++; $display("FAIL mz_end: got %h want %h", act, exp_vec());
    end
    cycle(1, 0, 16'h0000, 4'd1, 1, 1);
    total++;
    if (act !== exp_vec() || busy !== 1'b0) begin bad++; $display("FAIL mz_start: got %h want %h", act, exp_vec()); end
  endtask

  task automatic test_mask_change();
    do_reset();
    cycle(1, 0, 16'h0018, 4'd2, 0, 0);
    total++;
    if (sel !== 4'd3) begin bad++; $display("FAIL mc_start: got sel=%0d want sel=3", sel); end
    cycle(0, 0, 16'h0018, 4'd2, 1, 1);
    cycle(0, 0, 16'h0020, 4'd2, 1, 1);
    total++;
    if (act !== exp_vec() || y !== 16'h0008) begin bad++; $display("FAIL mc_mid: got %h want %h", act, exp_vec()); end
    cycle(0, 0, 16'h0020, 4'd2, 1, 1);
    total++;
    if (act !== exp_vec() || sel !== 4'd5 || wrap !== 1'b0 || y !== 16'h0008) begin
      bad++; $display("FAIL mc_end: got %h want %h", act, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [15:0] mask;
    do_reset();
    mask = 16'h0421;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0)
        mask = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom() & $urandom());
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0, mask,
            4'($urandom_range(0, 3)), 1'($urandom()), $urandom_range(0, 3) != 0);
      total++;
      if (act !== exp_vec()) begin bad++; $display("FAIL rand%0d: got %h want %h", i, act, exp_vec()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_skip_wrap();
    test_backpressure();
    test_stop_maskzero();
    test_mask_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_rr_sched.md
# demux_rr_sched

Round-robin time-slot scheduler that sequences the 1:16 demultiplexer datapath. It accepts a serial data stream through a valid/ready handshake and routes each accepted beat to one of 16 outputs. It dwells a programmable number of beats on each enabled channel, then advances to the next enabled channel, skipping masked channels and wrapping from 15 to 0. The select generation and the registered demux output both sit in this block, so downstream logic sees one-hot-routed data with a 1-cycle latency.

## Interface
- DWELL_W, 4, width of the dwell setting and the beat counter; slot length = dwell+1 beats (1..2^DWELL_W)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  begin scheduling; honoured only in IDLE
- stop  input  1  end scheduling at the next slot boundary
- en_mask  input  16  channel enable, bit i = channel i
- dwell  input  DWELL_W  beats per slot minus 1; sampled at each slot start
- din  input  1  serial data beat
- in_valid  input  1  din is valid
- in_ready  output  1  block accepts a beat this cycle
- sel  output  4  current channel (demux select)
- y  output  16  registered demux output; y[sel_at_accept] = din, all other bits 0
- dout_valid  output  1  y holds a beat accepted last cycle
- wrap  output  1  1-cycle pulse on a channel advance that wraps (new sel <= old sel)
- busy  output  1  state is RUN

## Operation
- States: IDLE, RUN.
- IDLE:
  - in_ready=0.
  - When start=1 and en_mask!=0: sel <= lowest set bit of en_mask, cnt <= 0, latch dwell, go RUN.
  - start with en_mask==0 is ignored.
- RUN:
  - in_ready=1.
  - Accept a beat when in_valid & in_ready. On accept: y <= din on bit sel, zeros elsewhere; dout_valid <= 1; cnt <= cnt+1.
  - No accept: dout_valid <= 0, y <= 0, cnt holds.
- Slot end: an accept with cnt == latched dwell.
  - stop pending (stop seen high at any cycle since the slot began, including this cycle): go IDLE, sel holds.
  - Else, if en_mask==0 this cycle: go IDLE.
  - Else: sel <= first set bit of en_mask searching sel+1, sel+2, … mod 16, including sel itself last. Set cnt <= 0, re-latch dwell, and pulse wrap if new sel <= old sel.
- en_mask is sampled only at slot start and slot end. Clearing the current channel's bit mid-slot does not cut the slot short.
- A single enabled channel re-selects itself every slot, with wrap=1 each time.
- start during RUN is ignored.
- A stop flag pending in IDLE is cleared on entry to RUN.

## Timing
- Reset values: state IDLE, sel=0, y=0, dout_valid=0, wrap=0, busy=0, in_ready=0, cnt=0, stop flag=0.
- Asynchronous reset mid-slot aborts immediately; any accepted-but-unpresented beat is lost.
- Latency: a beat accepted at edge k appears on y/dout_valid after edge k and holds for exactly one cycle.
- sel updates on the edge of the slot-end accept. The next accept uses the new sel with no bubble, and in_ready stays 1 across advances.
- start → first possible accept on the next cycle; busy rises at the same edge as the RUN entry.
- wrap is registered and aligned with the new sel.
- in_ready and busy are combinational decodes of state.

## Test plan
- Reset then idle: assert rst mid-run with in_valid=1 → all outputs 0 immediately, in_ready=0 until start.
- Basic rotation: en_mask=16'h0005, dwell=1, start, stream 1,0,1,1,0,1 continuously → routing sel=0,0,2,2,0,0.
  - y = 0001,0000,0004,0004,0000,0001.
  - wrap pulses after the 4th beat.
- Skip and wrap: en_mask=16'h8001, dwell=0 → sel alternates 0,15,0,15; wrap=1 on each 15→0 advance only.
- Backpressure gaps: in_valid toggles 1,0,0,1 with dwell=1 → cnt holds during gaps; slot ends on the 2nd accepted beat; dout_valid=1,0,0,1.
- Stop and mask-zero: stop pulsed on the 1st beat of a dwell=3 slot → all 4 beats are delivered, then IDLE.
  - Separately: en_mask cleared to 0 mid-slot → slot completes, then IDLE; start with en_mask=0 → stays IDLE.
- Mid-slot mask change: current sel=3, en_mask changed from 16'h0018 to 16'h0020 mid-slot → slot on 3 completes, then sel=5 with wrap=0.
